// File: rtl/pma_tx_serializer.sv
// Transmit PMA serializer: loads one encoded symbol per word period and shifts it out LSB-first,
// with word-rate handshake, line polarity inversion and electrical-idle control.
module pma_tx_serializer #(
    parameter int unsigned DATA_WIDTH = 10
) (
    input  logic                  CLK_5G,
    input  logic                  Rst_n,
    input  logic [DATA_WIDTH-1:0] Data_in,
    input  logic                  Data_valid,
    input  logic                  TxPolarity,
    input  logic                  TxElecIdle,
    output logic                  Data_ready,
    output logic                  Ser_out,
    output logic                  Word_clk,
    output logic                  Underrun,
    output logic                  Idle_active
);

    localparam int unsigned CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DATA_WIDTH - 1);
    localparam logic [CNT_W-1:0] CNT_HALF_M1 = CNT_W'(DATA_WIDTH / 2 - 1);

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACTIVE = 1'b1
    } state_t;

    state_t                r_state;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_ser_out;
    logic                  r_word_clk;
    logic                  r_underrun;
    logic                  r_idle_active;

    logic                  w_load;
    logic [DATA_WIDTH-1:0] w_pol_mask;
    logic [DATA_WIDTH-1:0] w_next_word;

    assign w_load     = (r_bit_cnt == CNT_LAST);
    assign w_pol_mask = {DATA_WIDTH{TxPolarity}};
    assign Data_ready = w_load && !TxElecIdle;

    // Word latched at a load edge; an ACTIVE underrun sends polarity-adjusted zeros, IDLE sends raw zeros.
    always_comb begin
        w_next_word = '0;
        if (!TxElecIdle) begin
            if (Data_valid) begin
                w_next_word = Data_in ^ w_pol_mask;
            end else if (r_state == S_ACTIVE) begin
                w_next_word = w_pol_mask;
            end
        end
    end

    always_ff @(posedge CLK_5G or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state       <= S_IDLE;
            r_bit_cnt     <= '0;
            r_shift       <= '0;
            r_ser_out     <= 1'b0;
            r_word_clk    <= 1'b0;
            r_underrun    <= 1'b0;
            r_idle_active <= 1'b1;
        end else begin
            r_underrun <= 1'b0;
            if (w_load) begin
                r_bit_cnt  <= '0;
                r_word_clk <= 1'b1;
                r_ser_out  <= w_next_word[0];
                r_shift    <= w_next_word >> 1;
                case (r_state)
                    S_IDLE: begin
                        if (!TxElecIdle && Data_valid) begin
                            r_state       <= S_ACTIVE;
                            r_idle_active <= 1'b0;
                        end
                    end
                    S_ACTIVE: begin
                        if (TxElecIdle) begin
                            r_state       <= S_IDLE;
                            r_idle_active <= 1'b1;
                        end else if (!Data_valid) begin
                            r_underrun <= 1'b1;
                        end
                    end
                    default: begin
                        r_state       <= S_IDLE;
                        r_idle_active <= 1'b1;
                    end
                endcase
            end else begin
                r_bit_cnt <= r_bit_cnt + CNT_W'(1);
                r_ser_out <= r_shift[0];
                r_shift   <= r_shift >> 1;
                // Falls on the edge where the count becomes DATA_WIDTH/2, giving a 50% duty cycle.
                if (r_bit_cnt == CNT_HALF_M1) begin
                    r_word_clk <= 1'b0;
                end
            end
        end
    end

    assign Ser_out     = r_ser_out;
    assign Word_clk    = r_word_clk;
    assign Underrun    = r_underrun;
    assign Idle_active = r_idle_active;

endmodule

// File: tb/tb_pma_tx_serializer.sv
// Scoreboard bench for pma_tx_serializer: a word-level model pushes per-cycle expectations,
// a negedge monitor pops and compares them against the serial outputs.
module tb_pma_tx_serializer;

    localparam int unsigned DW = 10;

    typedef struct packed {
        logic ser;
        logic wclk;
        logic und;
        logic idle;
        logic last;
    } rec_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic          data_valid = 1'b0;
    logic          tx_pol = 1'b0;
    logic          tx_eidle = 1'b0;
    logic          data_ready, ser_out, word_clk, underrun, idle_active;

    int   total = 0;
    int   bad = 0;
    rec_t q[$];
    int   ecount = 0;
    bit   m_active = 1'b0;

    pma_tx_serializer #(.DATA_WIDTH(DW)) dut (
        .CLK_5G     (clk),
        .Rst_n      (rst_n),
        .Data_in    (data_in),
        .Data_valid (data_valid),
        .TxPolarity (tx_pol),
        .TxElecIdle (tx_eidle),
        .Data_ready (data_ready),
        .Ser_out    (ser_out),
        .Word_clk   (word_clk),
        .Underrun   (underrun),
        .Idle_active(idle_active)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
        end
    endtask

    task automatic check_reset();
        check("rst_ser_out", ser_out, 1'b0);
        check("rst_word_clk", word_clk, 1'b0);
        check("rst_underrun", underrun, 1'b0);
        check("rst_data_ready", data_ready, 1'b0);
        check("rst_idle_active", idle_active, 1'b1);
    endtask

    // Word-level reference: every DW edges after reset release one word of DW bits is scheduled.
    always @(posedge clk or negedge rst_n) begin
        rec_t          r;
        logic [DW-1:0] word;
        bit            und;
        if (!rst_n) begin
            q.delete();
            ecount   = 0;
            m_active = 1'b0;
            for (int i = 0; i < int'(DW); i++) begin
                r = '{ser: 1'b0, wclk: 1'b0, und: 1'b0, idle: 1'b1, last: (i == int'(DW) - 1)};
                q.push_back(r);
            end
        end else begin
            ecount++;
            if (ecount % int'(DW) == 0) begin
                word = '0;
                und  = 1'b0;
                if (tx_eidle) begin
                    m_active = 1'b0;
                end else if (data_valid) begin
                    word     = data_in ^ {DW{tx_pol}};
                    m_active = 1'b1;
                end else if (m_active) begin
                    word = {DW{tx_pol}};
                    und  = 1'b1;
                end
                for (int i = 0; i < int'(DW); i++) begin
                    r = '{ser: word[i], wclk: (i < int'(DW) / 2), und: (und && i == 0),
                          idle: !m_active, last: (i == int'(DW) - 1)};
                    q.push_back(r);
                end
            end
        end
    end

    // Monitor: one expectation record per bit period.
    always @(negedge clk) begin
        rec_t r;
        if (rst_n) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL scoreboard_empty at %0t: got empty queue expected a record", $time);
            end else begin
                r = q.pop_front();
                check("ser_out", ser_out, r.ser);
                check("word_clk", word_clk, r.wclk);
                check("underrun", underrun, r.und);
                check("idle_active", idle_active, r.idle);
                check("data_ready", data_ready, r.last && !tx_eidle);
            end
        end
    end

    // One word period: DW-1 cycles of ignored noise, then the load-edge inputs. Optional mid-word reset.
    task automatic run_word(input logic v, input logic [DW-1:0] d, input logic p,
                            input logic e, input int rst_at);
        for (int c = 0; c < int'(DW) - 1; c++) begin
            data_in    = DW'($urandom);
            data_valid = 1'($urandom_range(0, 1));
            tx_pol     = 1'($urandom_range(0, 1));
            tx_eidle   = 1'($urandom_range(0, 1));
            if (c == rst_at) begin
                #2 rst_n = 1'b0;
                #1 check_reset();
                @(posedge clk);
                @(posedge clk);
                #1 rst_n = 1'b1;
                return;
            end
            @(posedge clk);
            #1;
        end
        data_in    = d;
        data_valid = v;
        tx_pol     = p;
        tx_eidle   = e;
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 check_reset();
        rst_n = 1'b1;

        run_word(1'b1, 10'b0101111100, 1'b0, 1'b0, -1);
        run_word(1'b1, 10'h17C, 1'b0, 1'b0, -1);
        run_word(1'b1, 10'h283, 1'b0, 1'b0, -1);
        run_word(1'b1, 10'h3FF, 1'b1, 1'b0, -1);
        run_word(1'b0, 10'h155, 1'b0, 1'b0, -1);
        run_word(1'b0, 10'h0AA, 1'b1, 1'b0, -1);
        run_word(1'b1, 10'h155, 1'b0, 1'b1, -1);
        run_word(1'b0, 10'h3FF, 1'b1, 1'b0, -1);
        run_word(1'b1, 10'h283, 1'b1, 1'b0, -1);
        run_word(1'b1, 10'h1E3, 1'b0, 1'b0, -1);
        run_word(1'b1, 10'h2A5, 1'b0, 1'b0, 4);
        run_word(1'b1, 10'h17C, 1'b0, 1'b0, -1);

        for (int w = 0; w < 120; w++) begin
            run_word(($urandom_range(0, 4) != 0), DW'($urandom), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 5) == 0), (w == 60) ? int'($urandom_range(0, 8)) : -1);
        end

        repeat (DW) @(posedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/pma_tx_serializer.md
Name: pma_tx_serializer

Overview:
- Transmit-side PMA block: takes one DATA_WIDTH-bit encoded symbol per word period from the PCS (8b/10b encoder path) and shifts it out serially, one bit per CLK_5G cycle.
- Provides the word-rate handshake, line polarity inversion and electrical-idle control.
- Its serial output feeds the channel toward the RX PMA serial-to-parallel path.

Parameters:
- DATA_WIDTH, 10, symbol width in bits and bits per word period. Must be ≥ 4 and even.

Ports:
- CLK_5G  in  1  bit-rate clock; all flops on rising edge
- Rst_n  in  1  asynchronous active-low reset
- Data_in  in  DATA_WIDTH  encoded symbol; bit 0 transmitted first
- Data_valid  in  1  Data_in holds a word for the current load edge
- TxPolarity  in  1  1 = invert every transmitted bit; sampled at load edge only
- TxElecIdle  in  1  1 = request electrical idle; sampled at load edge only
- Data_ready  out  1  word-request strobe, high for one cycle per word period
- Ser_out  out  1  registered serial data
- Word_clk  out  1  divided clock (CLK_5G / DATA_WIDTH) for the PCS
- Underrun  out  1  one-cycle pulse: ACTIVE word period started without Data_valid
- Idle_active  out  1  1 while FSM is in IDLE

Behaviour:
- Reset (async, Rst_n = 0):
  - bit_cnt = 0, shift register = 0, FSM = IDLE.
  - Outputs: Ser_out = 0, Word_clk = 0, Underrun = 0, Data_ready = 0, Idle_active = 1.
  - Deassertion is sampled normally. The first load edge is the 10th rising edge after reset release (DATA_WIDTH edges in general).
- bit_cnt counts 0..DATA_WIDTH-1 and wraps. A "load edge" is a rising edge with bit_cnt == DATA_WIDTH-1.
- Data_ready = (bit_cnt == DATA_WIDTH-1) && !TxElecIdle. It is decoded from the registered count.
- A word is accepted only at a load edge with Data_ready && Data_valid. No other handshake exists; Data_valid outside a load edge is ignored.
- Polarity: the loaded word is Data_in XOR {DATA_WIDTH{TxPolarity}}, latched at the load edge. A TxPolarity change mid-word has no effect until the next load edge.
- Timing for a word accepted at edge E:
  - Ser_out carries bit i during the cycle following edge E+i, for i = 0..DATA_WIDTH-1.
  - Back-to-back words produce a continuous bitstream with no gap.
- Word_clk: set at each load edge, cleared at the edge where bit_cnt becomes DATA_WIDTH/2. Duty cycle is 50%.
- FSM, evaluated at load edges only:
  - IDLE, TxElecIdle = 1: stay IDLE; Ser_out = 0 for the whole word.
  - IDLE, TxElecIdle = 0, Data_valid = 1: load the word, go to ACTIVE.
  - IDLE, TxElecIdle = 0, Data_valid = 0: stay IDLE; Ser_out = 0; no Underrun.
  - ACTIVE, TxElecIdle = 1: go to IDLE; Ser_out = 0 starting the next cycle; any Data_valid is ignored.
  - ACTIVE, Data_valid = 1: load the word, stay ACTIVE.
  - ACTIVE, Data_valid = 0: load all-zeros (then polarity applied), stay ACTIVE, pulse Underrun in the cycle after the load edge.
- In IDLE, Ser_out is 0 regardless of TxPolarity.
- Idle_active is the registered FSM state. It changes only in the cycle after a load edge.
- Reset mid-word: the in-flight word is discarded and all state returns to reset values immediately. No partial word is resumed.

Test Plan:
- Reset release, Data_valid = 1, Data_in = 10'b0101111100 held:
  - Data_ready first high after edge 9; word loaded at edge 10.
  - Ser_out = 0,0,1,1,1,1,1,0,1,0 over the next 10 cycles.
  - Idle_active falls after edge 10.
- Back-to-back words 10'h17C then 10'h283, TxPolarity = 0:
  - 20 contiguous Ser_out bits, LSB-first, no gap.
  - Exactly one Data_ready pulse per 10 cycles.
  - Word_clk period = 10 cycles, high for 5.
- TxPolarity = 1 at a load edge with Data_in = 10'h3FF:
  - Ser_out = 0 for 10 cycles.
  - TxPolarity toggled mid-word leaves the current word unchanged.
- ACTIVE with Data_valid = 0 at a load edge:
  - Ser_out = 0 for 10 cycles.
  - Underrun high for exactly one cycle after that load edge.
  - FSM stays ACTIVE.
- TxElecIdle = 1 at a load edge:
  - Data_ready stays low; Ser_out = 0; Idle_active = 1 after the edge.
  - After TxElecIdle = 0 with Data_valid = 0: stays IDLE, no Underrun.
  - With Data_valid = 1: loads the word and returns to ACTIVE.
- Rst_n pulsed low at bit 4 of a word:
  - Ser_out, Word_clk and Underrun go 0 immediately without waiting for a clock edge; Idle_active goes 1.
  - After release, the next load edge is the 10th edge.
